// File: rtl/rf2p_fifo_ctl_pkg.sv
// rtl/rf2p_fifo_ctl_pkg.sv - RF configuration defaults and derived sizes for the RF2P FIFO controller
package rf2p_fifo_ctl_pkg;

  localparam int DWD_DEF   = 16;
  localparam int AWD_DEF   = 4;
  localparam int DEPTH_DEF = 1 << AWD_DEF;

  // Total occupancy spans RF (0..DEPTH) + staging (0..2) + one in flight.
  function automatic int level_w(input int awd);
    return awd + 2;
  endfunction

endpackage

// File: rtl/rf2p_stage2.sv
// rtl/rf2p_stage2.sv - 2-entry FIFO-ordered staging buffer absorbing the RF read latency
module rf2p_stage2 #(
  parameter int DWd = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_clr,
  input  logic           i_push,
  input  logic [DWd-1:0] i_push_data,
  input  logic           i_pop,
  output logic [DWd-1:0] o_head,
  output logic [1:0]     o_cnt
);

  logic [DWd-1:0] ent0, ent1;
  logic [1:0]     cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= i_push_data;
          else             ent1 <= i_push_data;
          if (cnt != 2'd2) cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains.
          if (cnt == 2'd1) begin
            ent0 <= i_push_data;
          end else begin
            ent0 <= ent1;
            ent1 <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head = ent0;
  assign o_cnt  = cnt;

endmodule

// File: rtl/rf2p_fifo_ctl.sv
// rtl/rf2p_fifo_ctl.sv - stream FIFO controller in front of a 2-port RF; RF2P_FIFO_LEVEL_EN adds o_level
module rf2p_fifo_ctl
  import rf2p_fifo_ctl_pkg::*;
#(
  parameter int DWd = DWD_DEF,
  parameter int AWd = AWD_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_clr,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic [DWd-1:0] i_in_data,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [DWd-1:0] o_out_data,
  output logic           o_rf_read,
  output logic [AWd-1:0] o_rf_raddr,
  input  logic [DWd-1:0] i_rf_rdata,
  input  logic           i_rf_rvalid,
  output logic           o_rf_write,
  output logic [AWd-1:0] o_rf_waddr,
  output logic [DWd-1:0] o_rf_wdata
`ifdef RF2P_FIFO_LEVEL_EN
  ,
  output logic [level_w(AWd)-1:0] o_level
`endif
);

  localparam logic [AWd:0] DEPTH_CNT = {1'b1, {AWd{1'b0}}};

  logic [AWd-1:0] wptr, rptr;
  logic [AWd:0]   rf_cnt, rf_cnt_nxt;
  logic           inflight;
  logic [1:0]     stg_cnt;
  logic [DWd-1:0] stg_head;
  logic           wr, rd, pop, push;
  logic [2:0]     occ;

  always_comb begin
    o_in_ready  = (rf_cnt != DEPTH_CNT) & ~i_clr;
    wr          = i_in_valid & o_in_ready;
    o_out_valid = (stg_cnt != 2'd0) & ~i_clr;
    pop         = o_out_valid & i_out_ready;
    // Words already committed to staging: resident + arriving now - leaving now.
    occ         = {1'b0, stg_cnt} + {2'b00, inflight} - {2'b00, pop};
    rd          = (rf_cnt != '0) & (occ < 3'd2) & ~i_clr;
    push        = i_rf_rvalid & inflight & ~i_clr;
    rf_cnt_nxt  = rf_cnt;
    case ({wr, rd})
      2'b10:   rf_cnt_nxt = rf_cnt + 1'b1;
      2'b01:   rf_cnt_nxt = rf_cnt - 1'b1;
      default: rf_cnt_nxt = rf_cnt;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      rf_cnt   <= '0;
      inflight <= 1'b0;
    end else if (i_clr) begin
      wptr     <= '0;
      rptr     <= '0;
      rf_cnt   <= '0;
      inflight <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      rf_cnt   <= rf_cnt_nxt;
      inflight <= rd;
    end
  end

  rf2p_stage2 #(.DWd(DWd)) u_stage (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (i_clr),
    .i_push      (push),
    .i_push_data (i_rf_rdata),
    .i_pop       (pop),
    .o_head      (stg_head),
    .o_cnt       (stg_cnt)
  );

  assign o_out_data = stg_head;
  assign o_rf_read  = rd;
  assign o_rf_raddr = rptr;
  assign o_rf_write = wr;
  assign o_rf_waddr = wptr;
  assign o_rf_wdata = i_in_data;

`ifdef RF2P_FIFO_LEVEL_EN
  localparam int LW = level_w(AWd);
  logic [1:0] stg_cnt_nxt;

  assign stg_cnt_nxt = stg_cnt + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    o_level <= '0;
    else if (i_clr)  o_level <= '0;
    else             o_level <= LW'(rf_cnt_nxt) + LW'(stg_cnt_nxt) + LW'(rd);
  end
`endif

endmodule
